rv32v_divide_sequencer: RTL

RV32V_DIVIDE_SEQUENCER -- requirements
Module: rv32v_divide_sequencer

---
 rtl/rv32v_divide_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rv32v_divide_sequencer.sv
// Walks a vector divide element by element: issues each active element to a
// scalar divider, waits for its result and writes it back, then signals done.
module rv32v_divide_sequencer #(
  parameter int MAX_VL = 32,
  localparam int IW = $clog2(MAX_VL)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  logic [IW:0]       vl,
  input  logic              vm,
  input  logic [MAX_VL-1:0] vmask,
  input  logic              div_type_in,
  input  logic              is_signed_in,
  input  logic              flush,
  output logic [IW-1:0]     elem_idx,
  input  logic [31:0]       vs1_elem,
  input  logic [31:0]       vs2_elem,
  output logic [31:0]       vs1_data,
  output logic [31:0]       vs2_data,
  output logic              start_div,
  output logic              div_type,
  output logic              is_signed_div,
  input  logic              done_du,
  input  logic              busy_du,
  input  logic              exception_du,
  input  logic [31:0]       wdata_du,
  output logic              wb_valid,
  output logic [IW-1:0]     wb_idx,
  output logic [31:0]       wb_data,
  output logic              busy,
  output logic              done,
  output logic              exception
);

  // state  | meaning
  // IDLE   | waiting for start
  // ISSUE  | element idx: skip if masked off, else hand to divider when free
  // WAIT   | divider working on element idx
  // FINISH | all elements handled; done pulse follows
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  localparam logic [IW:0] VL_MAX = (IW + 1)'(MAX_VL);

  state_t            state;
  logic [IW:0]       vl_q;
  logic              vm_q;
  logic [MAX_VL-1:0] vmask_q;
  logic              div_type_q;
  logic              is_signed_q;
  logic [IW-1:0]     idx;
  logic              exc_flag;

  logic [IW:0] vl_clamped;
  logic        elem_active;
  logic        last_elem;

  assign vl_clamped  = (vl > VL_MAX) ? VL_MAX : vl;
  assign elem_active = vm_q | vmask_q[idx];
  assign last_elem   = ({1'b0, idx} == (vl_q - (IW + 1)'(1)));

  assign elem_idx      = idx;
  assign vs1_data      = vs1_elem;
  assign vs2_data      = vs2_elem;
  assign div_type      = div_type_q;
  assign is_signed_div = is_signed_q;
  assign busy          = (state != IDLE);

  // Combinational so the pulse lines up with the single ISSUE cycle it belongs to.
  assign start_div = nRST && !flush && (state == ISSUE) && elem_active && !busy_du;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= IDLE;
      idx         <= '0;
      vl_q        <= '0;
      vm_q        <= 1'b0;
      vmask_q     <= '0;
      div_type_q  <= 1'b0;
      is_signed_q <= 1'b0;
      exc_flag    <= 1'b0;
      wb_valid    <= 1'b0;
      wb_idx      <= '0;
      wb_data     <= '0;
      done        <= 1'b0;
      exception   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      done     <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              idx       <= '0;
              exc_flag  <= 1'b0;
              exception <= 1'b0;
              if (vl == '0) begin
                state <= FINISH;
              end else begin
                vl_q        <= vl_clamped;
                vm_q        <= vm;
                vmask_q     <= vmask;
                div_type_q  <= div_type_in;
                is_signed_q <= is_signed_in;
                state       <= ISSUE;
              end
            end
          end
          ISSUE: begin
            if (elem_active) begin
              if (!busy_du) state <= WAIT;
            end else if (last_elem) begin
              state <= FINISH;
            end else begin
              idx <= idx + IW'(1);
            end
          end
          WAIT: begin
            if (done_du) begin
              wb_valid <= 1'b1;
              wb_idx   <= idx;
              wb_data  <= wdata_du;
              exc_flag <= exc_flag | exception_du;
              if (last_elem) begin
                state <= FINISH;
              end else begin
                idx   <= idx + IW'(1);
                state <= ISSUE;
              end
            end
          end
          FINISH: begin
            done      <= 1'b1;
            exception <= exc_flag;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
